// File: rtl/hack_mem_pkg.sv
// Shared types and constants for the Hack data-memory responder.
// Holds the memory-map constants, the region decode helper and the screen write record.
package hack_mem_pkg;

    localparam logic [14:0] SCREEN_BASE  = 15'h4000;
    localparam int          SCREEN_WORDS = 8192;
    localparam logic [14:0] KBD_ADDR     = 15'h6000;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_SCREEN,
        REG_KBD,
        REG_UNMAPPED
    } mem_region_t;

    typedef struct packed {
        logic [12:0] addr;
        logic [15:0] data;
    } scr_wr_t;

    // RAM wins only below ram_words; the gap up to SCREEN_BASE stays unmapped.
    function automatic mem_region_t decode_region(input logic [14:0] addr, input int ram_words);
        logic [31:0] addr_wide;
        addr_wide = {17'd0, addr};
        if (addr_wide < 32'(ram_words)) begin
            return REG_RAM;
        end else if (addr >= SCREEN_BASE && addr < KBD_ADDR) begin
            return REG_SCREEN;
        end else if (addr == KBD_ADDR) begin
            return REG_KBD;
        end else begin
            return REG_UNMAPPED;
        end
    endfunction

endpackage

// File: rtl/scr_wr_fifo.sv
// Screen write FIFO: power-of-two depth, occupancy counter separates full from empty.
// Head entry is shown combinationally and never overwritten while it waits.
module scr_wr_fifo
    import hack_mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  scr_wr_t wr_data,
    output scr_wr_t rd_data,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    scr_wr_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == DEPTH_C);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/hack_data_mem.sv
// Hack CPU data memory: RAM, screen write FIFO, keyboard register, overflow flag.
// Define HACK_SCREEN_SHADOW_EN to build an 8192x16 shadow RAM that answers SCREEN reads.
module hack_data_mem
    import hack_mem_pkg::*;
#(
    parameter int RAM_WORDS  = 16384,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [14:0] address_m,
    input  logic        write_m,
    input  logic [15:0] out_m,
    output logic [15:0] in_m,
    input  logic        kbd_valid,
    input  logic [15:0] kbd_code,
    output logic        scr_valid,
    input  logic        scr_ready,
    output logic [12:0] scr_addr,
    output logic [15:0] scr_data,
    output logic        scr_overflow
);

    localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    mem_region_t       region;
    logic [RAM_AW-1:0] ram_idx;
    logic [12:0]       scr_off;
    logic [15:0]       ram [RAM_WORDS];
    logic [15:0]       ram_rd;
    logic [15:0]       shadow_rd;
    logic [15:0]       kbd_reg;
    logic              overflow_reg;
    logic              scr_push;
    logic              scr_pop;
    logic              fifo_full;
    logic              fifo_empty;
    scr_wr_t           push_entry;
    scr_wr_t           head_entry;

    assign region  = decode_region(address_m, RAM_WORDS);
    assign ram_idx = address_m[RAM_AW-1:0];
    // SCREEN spans 0x4000..0x5FFF, so the offset is just the low 13 address bits.
    assign scr_off = address_m[12:0];

    always_ff @(posedge clk) begin
        if (write_m && region == REG_RAM) begin
            ram[ram_idx] <= out_m;
        end
    end
    assign ram_rd = ram[ram_idx];

`ifdef HACK_SCREEN_SHADOW_EN
    logic [15:0] shadow [SCREEN_WORDS];

    // Shadow follows every CPU screen write, even those the FIFO drops.
    always_ff @(posedge clk) begin
        if (scr_push) begin
            shadow[scr_off] <= out_m;
        end
    end
    assign shadow_rd = shadow[scr_off];
`else
    assign shadow_rd = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kbd_reg <= '0;
        end else if (kbd_valid) begin
            kbd_reg <= kbd_code;
        end
    end

    assign scr_push   = write_m && (region == REG_SCREEN);
    assign scr_pop    = scr_valid && scr_ready;
    assign push_entry = '{addr: scr_off, data: out_m};

    scr_wr_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (scr_push),
        .pop    (scr_pop),
        .wr_data(push_entry),
        .rd_data(head_entry),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign scr_valid = !fifo_empty;
    assign scr_addr  = head_entry.addr;
    assign scr_data  = head_entry.data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (scr_push && fifo_full && !scr_pop) begin
            overflow_reg <= 1'b1;
        end
    end
    assign scr_overflow = overflow_reg;

    always_comb begin
        in_m = '0;
        case (region)
            REG_RAM:    in_m = ram_rd;
            REG_SCREEN: in_m = shadow_rd;
            REG_KBD:    in_m = kbd_reg;
            default:    in_m = '0;
        endcase
    end

endmodule
